// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and helpers for the transmit stream arbiter.
//   arb_state_t : arbiter FSM states (PAD/DROP only reachable when
//                 TX_ARB_LEN_ENFORCE_EN is defined)
//   rr_pick     : round-robin one-hot winner, searching upward from last+1
//   cnt_width   : payload word counter width for a given frame length
package tx_arb_pkg;

    typedef enum logic [1:0] {IDLE, FWD, PAD, DROP} arb_state_t;

    // Widest request vector rr_pick handles; callers zero-extend into it.
    localparam int MAX_SOURCES = 32;
    localparam int IDX_BITS    = $clog2(MAX_SOURCES);

    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

    // First requester at or after last+1, modulo n. Zero when req is empty.
    function automatic logic [MAX_SOURCES-1:0] rr_pick(
        input logic [MAX_SOURCES-1:0] req,
        input int                     n,
        input int                     last
    );
        logic [MAX_SOURCES-1:0] win;
        int                     pos;
        win = '0;
        for (int k = 1; k <= MAX_SOURCES; k++) begin
            pos = last + k;
            if (pos >= n) pos = pos - n;
            if (k <= n && win == '0 && req[pos[IDX_BITS-1:0]])
                win[pos[IDX_BITS-1:0]] = 1'b1;
        end
        return win;
    endfunction

endpackage

// File: rtl/tx_stream_arbiter_rr.sv
// rr_arbiter: round-robin pointer and winner selection.
//   clk, rst    : clock, synchronous active-high reset
//   req         : per-source request (tvalid)
//   advance     : winner accepted this cycle; moves last_grant to it
//   grant_next  : one-hot winner for the current req (zero if no request)
module rr_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_SOURCES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SOURCES-1:0] req,
    input  logic                   advance,
    output logic [NUM_SOURCES-1:0] grant_next
);

    localparam int IDX_W = $clog2(NUM_SOURCES);

    logic [IDX_W-1:0]       last_grant;
    logic [IDX_W-1:0]       win_idx;
    logic [MAX_SOURCES-1:0] req_wide;
    logic [MAX_SOURCES-1:0] pick;
    logic                   unused_pick_hi;

    always_comb begin
        req_wide   = MAX_SOURCES'(req);
        pick       = rr_pick(req_wide, NUM_SOURCES, int'(last_grant));
        grant_next = pick[NUM_SOURCES-1:0];
        win_idx    = '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            if (pick[i]) win_idx = IDX_W'(i);
    end

    // Bits above NUM_SOURCES are always zero.
    assign unused_pick_hi = |(pick >> NUM_SOURCES);

    // Starts at the top index so source 0 wins the first arbitration.
    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= IDX_W'(NUM_SOURCES - 1);
        else if (advance)
            last_grant <= win_idx;
    end

endmodule

// File: rtl/tx_stream_arbiter.sv
// tx_stream_arbiter: packet-level round-robin merge of NUM_SOURCES
// AXI-Stream payload sources into the Ethernet framer payload stream.
// The grant is held for a whole packet so payloads never interleave.
//   clk, rst        : clock, synchronous active-high reset
//   s_axis_*        : source streams, source i at slice i*WORD_BYTES*8
//   m_axis_*        : merged stream to the framer
//   grant           : one-hot current owner, zero when idle
//   busy            : a packet transfer is in progress
// Optional macro TX_ARB_LEN_ENFORCE_EN: every output packet is exactly
// PACKET_PAYLOAD_WORDS words (short packets zero-padded, long ones
// truncated with the excess source words discarded).
module tx_stream_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_SOURCES          = 4,
    parameter int WORD_BYTES           = 1,
    parameter int PACKET_PAYLOAD_WORDS = 64
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_SOURCES*WORD_BYTES*8-1:0] s_axis_tdata,
    input  logic [NUM_SOURCES-1:0]            s_axis_tvalid,
    input  logic [NUM_SOURCES-1:0]            s_axis_tlast,
    output logic [NUM_SOURCES-1:0]            s_axis_tready,
    output logic [WORD_BYTES*8-1:0]           m_axis_tdata,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [NUM_SOURCES-1:0]            grant,
    output logic                              busy
);

    localparam int DW = WORD_BYTES * 8;

    arb_state_t             state, state_n;
    logic [NUM_SOURCES-1:0] grant_n;
    logic [NUM_SOURCES-1:0] grant_next;
    logic                   advance;
    logic [DW-1:0]          src_data;
    logic                   src_valid;
    logic                   src_last;

`ifdef TX_ARB_LEN_ENFORCE_EN
    localparam int CNT_W = cnt_width(PACKET_PAYLOAD_WORDS);
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             last_word;
    // cnt holds words already sent, so this is true on word P.
    assign last_word = (cnt == CNT_W'(PACKET_PAYLOAD_WORDS - 1));
`else
    // Frame length only matters when enforcement is compiled in.
    localparam int UNUSED_PAYLOAD_WORDS = PACKET_PAYLOAD_WORDS;
`endif

    rr_arbiter #(.NUM_SOURCES(NUM_SOURCES)) u_rr (
        .clk        (clk),
        .rst        (rst),
        .req        (s_axis_tvalid),
        .advance    (advance),
        .grant_next (grant_next)
    );

    // Owner mux; grant is one-hot or zero, so an OR-reduce selects.
    always_comb begin
        src_data = '0;
        for (int i = 0; i < NUM_SOURCES; i++)
            if (grant[i]) src_data = s_axis_tdata[i*DW +: DW];
    end
    assign src_valid = |(s_axis_tvalid & grant);
    assign src_last  = |(s_axis_tlast & grant);

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
`ifdef TX_ARB_LEN_ENFORCE_EN
            cnt   <= '0;
`endif
        end else begin
            state <= state_n;
            grant <= grant_n;
`ifdef TX_ARB_LEN_ENFORCE_EN
            cnt   <= cnt_n;
`endif
        end
    end

    always_comb begin
        state_n       = state;
        grant_n       = grant;
        advance       = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = '0;
`ifdef TX_ARB_LEN_ENFORCE_EN
        cnt_n         = cnt;
`endif
        case (state)
            IDLE: begin
                if (|s_axis_tvalid) begin
                    advance = 1'b1;
                    grant_n = grant_next;
                    state_n = FWD;
`ifdef TX_ARB_LEN_ENFORCE_EN
                    cnt_n   = '0;
`endif
                end
            end
            FWD: begin
                m_axis_tdata  = src_data;
                m_axis_tvalid = src_valid;
                s_axis_tready = grant & {NUM_SOURCES{m_axis_tready}};
`ifdef TX_ARB_LEN_ENFORCE_EN
                // Output tlast is owned by the counter, not the source.
                m_axis_tlast = last_word;
                if (src_valid && m_axis_tready) begin
                    cnt_n = cnt + 1'b1;
                    if (last_word) begin
                        if (src_last) begin
                            state_n = IDLE;
                            grant_n = '0;
                        end else begin
                            state_n = DROP;
                        end
                    end else if (src_last) begin
                        state_n = PAD;
                    end
                end
`else
                m_axis_tlast = src_last;
                if (src_valid && m_axis_tready && src_last) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
`endif
            end
`ifdef TX_ARB_LEN_ENFORCE_EN
            PAD: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = last_word;
                if (m_axis_tready) begin
                    cnt_n = cnt + 1'b1;
                    if (last_word) begin
                        state_n = IDLE;
                        grant_n = '0;
                    end
                end
            end
            DROP: begin
                // Swallow the remainder of an over-long packet.
                s_axis_tready = grant;
                if (src_valid && src_last) begin
                    state_n = IDLE;
                    grant_n = '0;
                end
            end
`endif
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_tx_stream_arbiter.sv
module tb_tx_stream_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int P  = 64;
    localparam int BUDGET = 20000;

    logic                clk = 1'b0;
    logic                rst;
    logic [N*DW-1:0]     s_axis_tdata;
    logic [N-1:0]        s_axis_tvalid, s_axis_tlast, s_axis_tready;
    logic [DW-1:0]       m_axis_tdata;
    logic                m_axis_tvalid, m_axis_tlast, m_axis_tready;
    logic [N-1:0]        grant;
    logic                busy;

    tx_stream_arbiter #(
        .NUM_SOURCES(N), .WORD_BYTES(1), .PACKET_PAYLOAD_WORDS(P)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Source-side words still to be offered, {last, data}.
    logic [DW:0] src_q [N][$];
    // Reference model input: packet lengths and words per source.
    int          len_q [N][$];
    logic [DW:0] mdl_q [N][$];
    // Reference model output: expected framer words and owner order.
    logic [DW:0] exp_q [$];
    int          own_q [$];
    int          model_last = N - 1;

    int          rdy_mode = 0;
    logic [N-1:0] prev_grant = '0;
    int          idle_run = 0;
    bit          expect_bubble = 1'b0;
    int          out_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_pkt(input int s, input int len);
        logic [DW:0] w;
        len_q[s].push_back(len);
        for (int k = 0; k < len; k++) begin
            w = {1'(k == len - 1), DW'($urandom)};
            src_q[s].push_back(w);
            mdl_q[s].push_back(w);
        end
    endtask

    // Serve pending packets round-robin from the source after the last
    // winner; each packet is emitted whole before the next one.
    task automatic build_model();
        int s, len;
        logic [DW:0] w;
        while (1'b1) begin
            s = -1;
            for (int k = 1; k <= N; k++)
                if (s < 0 && len_q[(model_last + k) % N].size() > 0) s = (model_last + k) % N;
            if (s < 0) break;
            model_last = s;
            own_q.push_back(s);
            len = len_q[s].pop_front();
            for (int k = 0; k < len; k++) begin
                w = mdl_q[s].pop_front();
`ifdef TX_ARB_LEN_ENFORCE_EN
                if (k < P) exp_q.push_back({1'(k == P - 1), w[DW-1:0]});
`else
                exp_q.push_back(w);
`endif
            end
`ifdef TX_ARB_LEN_ENFORCE_EN
            for (int k = len; k < P; k++) exp_q.push_back({1'(k == P - 1), DW'(0)});
`endif
        end
    endtask

    function automatic bit pending();
        bit p = 1'b0;
        for (int i = 0; i < N; i++) if (src_q[i].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                s_axis_tvalid[i] = 1'b1;
                {s_axis_tlast[i], s_axis_tdata[i*DW +: DW]} = src_q[i][0];
            end else begin
                s_axis_tvalid[i] = 1'b0;
                s_axis_tlast[i]  = 1'b0;
                s_axis_tdata[i*DW +: DW] = '0;
            end
        end
        m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) begin
            src_q[i].delete(); len_q[i].delete(); mdl_q[i].delete();
        end
        exp_q.delete();
        own_q.delete();
    endtask

    // Called just after a rising edge: model the packets, present them.
    task automatic load();
        build_model();
        idle_run = 0;
        expect_bubble = 1'b1;
        drive();
    endtask

    task automatic step();
        logic [N-1:0] src_hs, exp_g;
        logic [DW:0]  w;
        @(negedge clk);
        src_hs = s_axis_tvalid & s_axis_tready;
        check("one_hot", 64'($countones(grant) <= 1), 64'd1);
        check("busy", 64'(busy), 64'(|grant));
        check("foreign_ready", 64'(s_axis_tready & ~grant), 64'd0);
        if (grant == '0) check("idle_quiet", 64'({m_axis_tvalid, s_axis_tready}), 64'd0);
`ifndef TX_ARB_LEN_ENFORCE_EN
        if (grant != '0) check("owner_ready", 64'(s_axis_tready), 64'(grant & {N{m_axis_tready}}));
`endif
        if (grant != '0 && prev_grant == '0) begin
            if (expect_bubble) check("grant_gap", 64'(idle_run), 64'd1);
            expect_bubble = 1'b0;
            exp_g = '0;
            if (own_q.size() > 0) exp_g = N'(1) << own_q.pop_front();
            check("grant_owner", 64'(grant), 64'(exp_g));
        end
        if (grant == '0) begin
            if (prev_grant != '0) begin
                expect_bubble = 1'b1;
                idle_run = 1;
            end else begin
                idle_run++;
            end
        end
        if (m_axis_tvalid && m_axis_tready) begin
            out_cnt++;
            w = 'x;
            if (exp_q.size() > 0) w = exp_q.pop_front();
            check("out_word", 64'({m_axis_tlast, m_axis_tdata}), 64'(w));
        end
        prev_grant = grant;
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            if (src_hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        drive();
    endtask

    task automatic run_pkts(input string tag);
        int cyc = 0;
        while (cyc < BUDGET && (exp_q.size() != 0 || pending() || busy)) begin
            step();
            cyc++;
        end
        check({tag, "_timeout"}, 64'(cyc < BUDGET), 64'd1);
        step();
        step();
        check({tag, "_words_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_owners_left"}, 64'(own_q.size()), 64'd0);
    endtask

    // Entered just after a rising edge with rst low; leaves the same way.
    task automatic reset_check(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        flush();
        drive();
        @(negedge clk);
        check(tag, 64'({m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready, grant, busy}), 64'd0);
        prev_grant = grant;
        expect_bubble = 1'b0;
        model_last = N - 1;
        @(posedge clk); #1;
    endtask

    initial begin
        int cyc;
        rst = 1'b1;
        s_axis_tvalid = '0;
        s_axis_tlast  = '0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;
        @(posedge clk); #1;
        reset_check("reset_state");

        // Single source 2, one full-length packet, framer always ready.
        rdy_mode = 0;
        out_cnt = 0;
        add_pkt(2, P);
        load();
        run_pkts("single");
        check("single_count", 64'(out_cnt), 64'(P));

        // All sources request continuously: rotation 0,1,2,3,0,...
        reset_check("reset_before_rr");
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < N; s++) add_pkt(s, $urandom_range(1, P + 6));
        load();
        run_pkts("rotation");

        // Backpressure on source 1.
        rdy_mode = 1;
        add_pkt(1, P);
        add_pkt(1, $urandom_range(1, P + 6));
        load();
        run_pkts("backpressure");

        // Random mixes, including one-word packets.
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < N; s++)
                repeat ($urandom_range(0, 2)) add_pkt(s, $urandom_range(1, P + 6));
            if (it == 0) add_pkt(1, 1);
            load();
            run_pkts("random");
        end

        // Length boundaries: short, long, exact.
        add_pkt(0, 10);
        add_pkt(3, P + 6);
        add_pkt(2, P);
        add_pkt(1, P - 1);
        add_pkt(1, P + 1);
        load();
        run_pkts("length");

        // Reset in the middle of a packet from source 1.
        add_pkt(1, P);
        load();
        out_cnt = 0;
        cyc = 0;
        while (out_cnt < 19 && cyc < BUDGET) begin
            step();
            cyc++;
        end
        check("mid_reach", 64'(out_cnt), 64'd19);
        reset_check("reset_mid_packet");
        for (int s = 0; s < N; s++) add_pkt(s, $urandom_range(1, 12));
        load();
        run_pkts("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
